uart_rx_recorder: RTL and testbench

- Write-side counterpart of the 512x8 read-only message ROM.
- Captures the byte stream from the UART receiver into a 512x8 block RAM, starting at address 0, until a terminator byte arrives or the buffer fills.
- A single registered read port lets downstream logic (checksum, echo transmitter, debug) read back the recorded message.
- Sits between uart_rx and any consumer of a received message.

---
 rtl/uart_rx_recorder.sv | 100 ++++++++++
 tb/tb_uart_rx_recorder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_recorder.sv
// Records a received UART byte stream into a DEPTH x 8 RAM until a terminator byte or a full buffer.
// Optional running checksum is built only when UART_RX_RECORDER_CHECKSUM_EN is defined.
module uart_rx_recorder #(
  parameter int unsigned DEPTH      = 512,
  parameter logic [7:0]  TERMINATOR = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  input  logic       i_clear,
  input  logic [8:0] i_raddr,
  output logic [7:0] o_rdata,
  output logic [9:0] o_count,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_full,
  output logic [7:0] o_checksum
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [9:0]  DepthCnt = 10'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRecord, StDone} state_e;

  state_e     state_q, state_d;
  logic [9:0] count_q, count_d;
  logic       we;

  logic [7:0] mem [DEPTH] = '{default: 8'h00};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    we      = 1'b0;
    // Clear beats a coincident strobe; DONE ignores strobes.
    if (i_clear) begin
      state_d = StIdle;
      count_d = '0;
    end else if (i_valid && (state_q != StDone)) begin
      we      = 1'b1;
      count_d = count_q + 10'd1;
      if ((i_data == TERMINATOR) || (count_d == DepthCnt)) begin
        state_d = StDone;
      end else begin
        state_d = StRecord;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_full  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      o_busy  <= (state_d == StRecord);
      o_done  <= (state_d == StDone);
      o_full  <= (count_d == DepthCnt);
    end
  end

  assign o_count = count_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[count_q[AW-1:0]] <= i_data;
    end
  end

  // Non-blocking read of the pre-write contents gives read-before-write.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_rdata <= 8'h00;
    end else begin
      o_rdata <= mem[i_raddr[AW-1:0]];
    end
  end

`ifdef UART_RX_RECORDER_CHECKSUM_EN
  logic [7:0] checksum_q;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      checksum_q <= 8'h00;
    end else if (we) begin
      checksum_q <= checksum_q + i_data;
    end
  end

  assign o_checksum = checksum_q;
`else
  assign o_checksum = 8'h00;
`endif

endmodule

// File: tb/tb_uart_rx_recorder.sv
// Self-checking bench for uart_rx_recorder against a simple buffer-and-counter reference model.
module tb_uart_rx_recorder;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid;
  logic [7:0] i_data;
  logic       i_clear;
  logic [8:0] i_raddr;
  logic [7:0] o_rdata;
  logic [9:0] o_count;
  logic       o_busy;
  logic       o_done;
  logic       o_full;
  logic [7:0] o_checksum;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: buffer contents, bytes stored, stop flag, byte sum.
  logic [7:0] mem_m [512];
  int         cnt_m;
  bit         done_m;
  logic [7:0] sum_m;

  uart_rx_recorder dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .i_clear    (i_clear),
    .i_raddr    (i_raddr),
    .o_rdata    (o_rdata),
    .o_count    (o_count),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_full     (o_full),
    .o_checksum (o_checksum)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] stat_act();
    return {o_count, o_busy, o_done, o_full, o_checksum};
  endfunction

  function automatic logic [20:0] stat_exp();
    logic [7:0] s;
`ifdef UART_RX_RECORDER_CHECKSUM_EN
    s = sum_m;
`else
    s = 8'h00;
`endif
    return {10'(cnt_m), (cnt_m > 0) && !done_m, done_m, cnt_m == 512, s};
  endfunction

  task automatic model_clear();
    cnt_m  = 0;
    done_m = 1'b0;
    sum_m  = 8'h00;
  endtask

  // All tasks start and end on a negative edge.
  task automatic send(input logic [7:0] b);
    i_valid = 1'b1;
    i_data  = b;
    if (!done_m) begin
      mem_m[cnt_m] = b;
      cnt_m++;
      sum_m += b;
      if (b == 8'h00 || cnt_m == 512) done_m = 1'b1;
    end
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic clear();
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
    model_clear();
  endtask

  task automatic do_read(input int addr, output logic [7:0] got);
    i_raddr = 9'(addr);
    @(negedge clk);
    got = o_rdata;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (stat_act() !== 21'h0 || o_rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_values: got stat=%h rdata=%h, want stat=0 rdata=00", stat_act(), o_rdata);
    end
    rst = 1'b0;
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_hello();
    logic [7:0] msg [6] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h00};
    logic [7:0] got;
    foreach (msg[i]) begin
      send(msg[i]);
      @(negedge clk);
    end
    n_tests++;
    if (stat_act() !== stat_exp() || o_count !== 10'd6 || o_done !== 1'b1) begin
      n_fail++;
      $display("FAIL hello_status: got %h, want %h", stat_act(), stat_exp());
    end
`ifdef UART_RX_RECORDER_CHECKSUM_EN
    n_tests++;
    if (o_checksum !== 8'hF4) begin
      n_fail++;
      $display("FAIL hello_checksum: got %h, want f4", o_checksum);
    end
`endif
    foreach (msg[i]) begin
      do_read(i, got);
      n_tests++;
      if (got !== msg[i]) begin
        n_fail++;
        $display("FAIL hello_read[%0d]: got %h, want %h", i, got, msg[i]);
      end
    end
  endtask

  task automatic test_fill();
    logic [7:0] got;
    clear();
    for (int i = 0; i < 600; i++) send(8'((i % 255) + 1));
    n_tests++;
    if (stat_act() !== stat_exp() || o_full !== 1'b1 || o_count !== 10'd512) begin
      n_fail++;
      $display("FAIL fill_status: got %h, want %h", stat_act(), stat_exp());
    end
    do_read(511, got);
    n_tests++;
    if (got !== 8'h02) begin
      n_fail++;
      $display("FAIL fill_last: got %h, want 02", got);
    end
    for (int k = 0; k < 8; k++) begin
      int a = int'($urandom_range(0, 511));
      do_read(a, got);
      n_tests++;
      if (got !== mem_m[a]) begin
        n_fail++;
        $display("FAIL fill_read[%0d]: got %h, want %h", a, got, mem_m[a]);
      end
    end
  endtask

  task automatic test_term_first();
    logic [7:0] got;
    clear();
    send(8'h00);
    n_tests++;
    if (stat_act() !== stat_exp() || o_done !== 1'b1 || o_count !== 10'd1) begin
      n_fail++;
      $display("FAIL term_first_status: got %h, want %h", stat_act(), stat_exp());
    end
    send(8'h55);
    do_read(0, got);
    n_tests++;
    if (got !== 8'h00 || o_count !== 10'd1) begin
      n_fail++;
      $display("FAIL term_first_mem: got mem0=%h count=%0d, want 00 and 1", got, o_count);
    end
  endtask

  task automatic test_clear_collision();
    logic [7:0] got;
    clear();
    for (int i = 0; i < 3; i++) begin
      send(8'($urandom_range(1, 255)));
      @(negedge clk);
    end
    i_clear = 1'b1;
    i_valid = 1'b1;
    i_data  = 8'hAA;
    @(negedge clk);
    i_clear = 1'b0;
    i_valid = 1'b0;
    model_clear();
    n_tests++;
    if (stat_act() !== stat_exp()) begin
      n_fail++;
      $display("FAIL clear_status: got %h, want %h", stat_act(), stat_exp());
    end
    do_read(3, got);
    n_tests++;
    if (got !== mem_m[3]) begin
      n_fail++;
      $display("FAIL clear_dropped: got mem3=%h, want %h", got, mem_m[3]);
    end
    send(8'h11);
    do_read(0, got);
    n_tests++;
    if (got !== 8'h11 || stat_act() !== stat_exp()) begin
      n_fail++;
      $display("FAIL clear_rearm: got mem0=%h stat=%h, want 11 stat=%h", got, stat_act(), stat_exp());
    end
  endtask

  task automatic test_rst_mid();
    logic [7:0] got;
    clear();
    for (int i = 0; i < 4; i++) begin
      send(8'($urandom_range(3, 255)));
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (stat_act() !== 21'h0 || o_rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_mid_values: got stat=%h rdata=%h, want 0 and 00", stat_act(), o_rdata);
    end
    rst = 1'b0;
    model_clear();
    do_read(2, got);
    n_tests++;
    if (got !== mem_m[2]) begin
      n_fail++;
      $display("FAIL rst_mid_keep: got mem2=%h, want %h", got, mem_m[2]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] old;
    clear();
    old = mem_m[1];
    i_raddr = 9'd1;
    send(8'h01);
    send(8'h02);
    n_tests++;
    if (o_rdata !== old) begin
      n_fail++;
      $display("FAIL b2b_old: got %h, want %h", o_rdata, old);
    end
    @(negedge clk);
    n_tests++;
    if (o_rdata !== 8'h02 || stat_act() !== stat_exp()) begin
      n_fail++;
      $display("FAIL b2b_new: got rdata=%h stat=%h, want 02 stat=%h", o_rdata, stat_act(), stat_exp());
    end
  endtask

  task automatic test_random();
    logic [7:0] got;
    for (int r = 0; r < 6; r++) begin
      int n = int'($urandom_range(1, 40));
      clear();
      for (int i = 0; i < n; i++) begin
        logic [7:0] b = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        send(b);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      n_tests++;
      if (stat_act() !== stat_exp()) begin
        n_fail++;
        $display("FAIL random_status[%0d]: got %h, want %h", r, stat_act(), stat_exp());
      end
      for (int a = 0; a <= cnt_m; a++) begin
        do_read(a, got);
        n_tests++;
        if (got !== mem_m[a]) begin
          n_fail++;
          $display("FAIL random_read[%0d][%0d]: got %h, want %h", r, a, got, mem_m[a]);
        end
      end
    end
  endtask

  initial begin
    foreach (mem_m[i]) mem_m[i] = 8'h00;
    model_clear();
    rst     = 1'b1;
    i_valid = 1'b0;
    i_data  = 8'h00;
    i_clear = 1'b0;
    i_raddr = 9'd0;
    @(negedge clk);
    test_reset();
    test_hello();
    test_fill();
    test_term_first();
    test_clear_collision();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
